// File: rtl/uart_tx_frame_gen.sv
// +-----------------------------------------------------------------------------
// | Module   : uart_tx_frame_gen
// | Brief    : UART transmit framer: start, LSB-first data, optional parity, stop.
// |            Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2).
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module uart_tx_frame_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [PRESCALE_WIDTH-1:0] c_min_prescale = PRESCALE_WIDTH'(2);
  localparam logic [PRESCALE_WIDTH-1:0] c_presc_one    = PRESCALE_WIDTH'(1);
  localparam logic [IDX_W-1:0]          c_idx_one      = IDX_W'(1);
  localparam logic [IDX_W-1:0]          c_last_idx     = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
`else
    S_STOP   = 3'd4
`endif
  } state_t;

  state_t                    state_q,   state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q,     cnt_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic [DATA_WIDTH-1:0]     data_q,    data_d;
  logic                      par_en_q,  par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [PRESCALE_WIDTH-1:0] presc_q,   presc_d;
  logic                      tx_q,      tx_d;
  logic                      busy_q,    busy_d;

  logic [PRESCALE_WIDTH-1:0] w_presc_eff;
  logic                      w_bit_done;
  logic                      w_data_bit;

  // Prescale values below 2 would make a bit shorter than the counter can resolve.
  assign w_presc_eff = (prescale < c_min_prescale) ? c_min_prescale : prescale;
  assign w_bit_done  = (cnt_q == (presc_q - c_presc_one));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    w_data_bit = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = w_bit_done ? '0 : (cnt_q + c_presc_one);
    end

    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          data_d    = p_data;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          presc_d   = w_presc_eff;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (w_bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_bit_done) begin
          if (idx_q == c_last_idx) begin
            idx_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + c_idx_one;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_done) state_d = S_STOP;
      end
      S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (w_bit_done) state_d = S_STOP2;
`else
        if (w_bit_done) state_d = S_IDLE;
`endif
      end
`ifdef UART_TX_TWO_STOP_EN
      S_STOP2: begin
        if (w_bit_done) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so tx_out/busy leave a flop glitch-free.
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (idx_d == IDX_W'(i)) w_data_bit = data_d[i];
    end

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = w_data_bit;
      S_PARITY: tx_d = (^data_d) ^ par_typ_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame_gen.sv
// +-----------------------------------------------------------------------------
// | Module   : tb_uart_tx_frame_gen
// | Brief    : Directed table-driven bench for uart_tx_frame_gen (default build).
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_frame_gen;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;

  int n_checks;
  int n_passed;

  uart_tx_frame_gen #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq holds the line level of each bit in transmit order; eff is clocks per bit.
  typedef struct {
    string         name;
    logic [PW-1:0] presc;
    logic [DW-1:0] data;
    logic          pen;
    logic          ptyp;
    int            eff;
    string         seq;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Call at a negedge right after data_valid is driven; samples every clock of the frame.
  task automatic check_frame(input string name, input string seq, input int eff, input bit hold);
    int n;
    int bad_tx;
    int bad_busy;
    logic exp_tx;
    n = seq.len() * eff;
    bad_tx = 0;
    bad_busy = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp_tx = (seq.getc(k / eff) == "1");
      if (tx_out !== exp_tx) bad_tx++;
      if (busy !== 1'b1) bad_busy++;
      if (!hold) data_valid = (k == 3);
      par_en   = ~par_en;
      par_typ  = ~par_typ;
      p_data   = DW'($urandom);
      prescale = PW'($urandom);
    end
    check({name, " line mismatching clocks"}, bad_tx, 0);
    check({name, " busy-low clocks in frame"}, bad_busy, 0);
  endtask

  task automatic check_idle(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check({name, " non-idle clocks"}, bad, 0);
  endtask

  task automatic start(input logic [PW-1:0] ps, input logic [DW-1:0] d,
                       input logic pe, input logic pt);
    prescale   = ps;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;

    vecs[0] = '{"p8_A5_even",  6'd8,  8'hA5, 1'b1, 1'b0, 8,  "01010010101"};
    vecs[1] = '{"p16_3C_odd",  6'd16, 8'h3C, 1'b1, 1'b1, 16, "00011110011"};
    vecs[2] = '{"p32_FF_nopar",6'd32, 8'hFF, 1'b0, 1'b0, 32, "0111111111"};
    vecs[3] = '{"p1_00_odd",   6'd1,  8'h00, 1'b1, 1'b1, 2,  "00000000011"};
    vecs[4] = '{"p0_01_nopar", 6'd0,  8'h01, 1'b0, 1'b0, 2,  "0100000001"};

    // Reset held while a request is presented: nothing may start.
    rst = 1'b0;
    start(6'd8, 8'hAA, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("reset tx_out", int'(tx_out), 1);
    check("reset busy", int'(busy), 0);
    rst = 1'b1;
    data_valid = 1'b0;
    check_idle("post-reset", 100);

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      start(vecs[v].presc, vecs[v].data, vecs[v].pen, vecs[v].ptyp);
      check_frame(vecs[v].name, vecs[v].seq, vecs[v].eff, 1'b0);
      data_valid = 1'b0;
      check_idle({vecs[v].name, " after frame"}, 4);
    end

    // Back-to-back with data_valid held: one idle clock, each frame uses its own config.
    @(negedge clk);
    start(6'd8, 8'h55, 1'b1, 1'b0);
    check_frame("b2b frame1", "01010101001", 8, 1'b1);
    start(6'd8, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b gap tx_out", int'(tx_out), 1);
    check("b2b gap busy", int'(busy), 0);
    check_frame("b2b frame2", "0111100001", 8, 1'b0);
    data_valid = 1'b0;
    check_idle("b2b after", 4);

    // Abort during data bit 3 (clocks 32..39 of the frame), then a clean 0x81 frame.
    @(negedge clk);
    start(6'd8, 8'h81, 1'b0, 1'b0);
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
    check("abort pre tx_out (bit3)", int'(tx_out), 0);
    check("abort pre busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort async tx_out", int'(tx_out), 1);
    check("abort async busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    check_idle("abort recovery", 3);
    start(6'd8, 8'h81, 1'b0, 1'b0);
    check_frame("post-abort 81", "0100000011", 8, 1'b0);
    data_valid = 1'b0;
    check_idle("post-abort after", 4);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
